// File: rtl/prbs_gen_chk.sv
// PRBS7/15/23/31 generator and self-synchronising checker with lock tracking.
// Optional PRBS_ERR_INJECT_EN adds inject_err to flip one generated bit.
module prbs_gen_chk #(
    parameter int DATA_W        = 1,
    parameter int CNT_W         = 16,
    parameter int LOCK_THRESH   = 64,
    parameter int UNLOCK_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gen_en,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] gen_data,
    input  logic              chk_valid,
    input  logic [DATA_W-1:0] chk_data,
    input  logic              clr_cnt,
`ifdef PRBS_ERR_INJECT_EN
    input  logic              inject_err,
`endif
    output logic              locked,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  err_count
);

    localparam int CW = $clog2(LOCK_THRESH + DATA_W + 1);
    localparam int EW = $clog2(UNLOCK_THRESH + 1);
    localparam int SW = CNT_W + 5;

    typedef enum logic {HUNT, LOCK} state_t;

    state_t            state;
    logic [1:0]        mode_q;
    logic              mode_chg;
    logic [30:0]       gen_s;
    logic [30:0]       gen_s_nxt;
    logic [DATA_W-1:0] gen_w;
    logic [DATA_W-1:0] gen_word;
    logic [30:0]       chk_s;
    logic [30:0]       chk_s_nxt;
    logic [3:0]        err_bits;
    logic [CW-1:0]     clean_cnt;
    logic [CW-1:0]     clean_nxt;
    logic [EW-1:0]     ew_cnt;
    logic [EW-1:0]     ew_nxt;
    logic [SW-1:0]     sum;
    logic [CNT_W-1:0]  sat_val;

    // Feedback bit: degree tap xor inner tap of the selected polynomial
    function automatic logic fb(input logic [30:0] s, input logic [1:0] m);
        logic r;
        unique case (m)
            2'd0: r = s[6] ^ s[5];
            2'd1: r = s[14] ^ s[13];
            2'd2: r = s[22] ^ s[17];
            2'd3: r = s[30] ^ s[27];
        endcase
        return r;
    endfunction

    assign mode_chg = (mode != mode_q);
    assign locked   = (state == LOCK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode_q <= 2'd0;
        else        mode_q <= mode;
    end

    always_comb begin
        gen_s_nxt = gen_s;
        gen_w     = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            gen_w[i]  = fb(gen_s_nxt, mode_q);
            gen_s_nxt = {gen_s_nxt[29:0], gen_w[i]};
        end
    end

`ifdef PRBS_ERR_INJECT_EN
    logic inj_q;
    logic inj_pend;
    logic inj_now;

    assign inj_now  = inj_pend | (inject_err & ~inj_q);
    assign gen_word = gen_w ^ (DATA_W'(inj_now) << (DATA_W - 1));

    // A request stays pending until a word is actually generated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_q    <= 1'b0;
            inj_pend <= 1'b0;
        end else begin
            inj_q    <= inject_err;
            inj_pend <= inj_now & ~(gen_en & ~mode_chg);
        end
    end
`else
    assign gen_word = gen_w;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_s    <= '1;
            gen_data <= '0;
        end else if (mode_chg) begin
            gen_s <= '1;
        end else if (gen_en) begin
            gen_s    <= gen_s_nxt;
            gen_data <= gen_word;
        end
    end

    // Received bits, not predictions, feed the checker register
    always_comb begin
        chk_s_nxt = chk_s;
        err_bits  = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            err_bits  = err_bits + {3'b000, chk_data[i] ^ fb(chk_s_nxt, mode_q)};
            chk_s_nxt = {chk_s_nxt[29:0], chk_data[i]};
        end
    end

    assign clean_nxt = clean_cnt + CW'(DATA_W);
    assign ew_nxt    = ew_cnt + EW'(1);
    assign sum       = SW'(err_count) + SW'(err_bits);
    assign sat_val   = (|sum[SW-1:CNT_W]) ? '1 : sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            chk_s     <= '1;
            clean_cnt <= '0;
            ew_cnt    <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else if (mode_chg) begin
            state     <= HUNT;
            chk_s     <= '1;
            clean_cnt <= '0;
            ew_cnt    <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (chk_valid) begin
                chk_s <= chk_s_nxt;
                unique case (state)
                    HUNT: begin
                        if (err_bits != 4'd0) begin
                            clean_cnt <= '0;
                        end else if (clean_nxt >= CW'(LOCK_THRESH)) begin
                            state     <= LOCK;
                            clean_cnt <= '0;
                            ew_cnt    <= '0;
                        end else begin
                            clean_cnt <= clean_nxt;
                        end
                    end
                    LOCK: begin
                        if (err_bits != 4'd0) begin
                            err_pulse <= 1'b1;
                            err_count <= sat_val;
                            if (ew_nxt >= EW'(UNLOCK_THRESH)) begin
                                state     <= HUNT;
                                clean_cnt <= '0;
                                ew_cnt    <= '0;
                            end else begin
                                ew_cnt <= ew_nxt;
                            end
                        end else begin
                            ew_cnt <= '0;
                        end
                    end
                endcase
            end
            if (clr_cnt) err_count <= '0;
        end
    end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench for prbs_gen_chk: generator scoreboard, lock, errors, saturation.
// Two instances: default (DATA_W=1) and a 4-bit-word / 4-bit-counter variant.
module tb_prbs_gen_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        gen_en, chk_valid, clr_cnt;
    logic [1:0]  mode;
    logic [0:0]  gen_data, chk_data;
    logic        locked, err_pulse;
    logic [15:0] err_count;

    logic        s_gen_en, s_chk_valid, s_clr;
    logic [1:0]  s_mode;
    logic [3:0]  s_gen_data, s_chk_data;
    logic        s_locked, s_err_pulse;
    logic [3:0]  s_err_count;

    int n_pass = 0, n_chk = 0, n_fail = 0;
    int pulses, s_pulses, lost, lock_at, lb, mism;
    logic flip, s_inv;

    logic [30:0] m_st, s_st;
    logic [1:0]  m_mode;
    logic [0:0]  m_last;
    logic [3:0]  s_last;
    logic [0:0]  exp_q[$];
    logic [3:0]  s_exp_q[$];
    logic [0:0]  hist[300];
    logic [6:0]  first7;

    prbs_gen_chk u_dut (
        .clk(clk), .rst_n(rst_n), .gen_en(gen_en), .mode(mode),
        .gen_data(gen_data), .chk_valid(chk_valid), .chk_data(chk_data),
        .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count)
    );

    prbs_gen_chk #(.DATA_W(4), .CNT_W(4), .LOCK_THRESH(64), .UNLOCK_THRESH(1000)) u_sat (
        .clk(clk), .rst_n(rst_n), .gen_en(s_gen_en), .mode(s_mode),
        .gen_data(s_gen_data), .chk_valid(s_chk_valid), .chk_data(s_chk_data),
        .clr_cnt(s_clr), .locked(s_locked), .err_pulse(s_err_pulse),
        .err_count(s_err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference LFSR: w bits per word, first bit in time lands in the MSB
    task automatic model_word(inout logic [30:0] st, input int w, input logic [1:0] m,
                              output logic [7:0] r);
        int n, t;
        logic b;
        case (m)
            2'd0: begin n = 7;  t = 6;  end
            2'd1: begin n = 15; t = 14; end
            2'd2: begin n = 23; t = 18; end
            default: begin n = 31; t = 28; end
        endcase
        r = '0;
        for (int i = w - 1; i >= 0; i--) begin
            b = st[n-1] ^ st[t-1];
            r[i] = b;
            st = {st[29:0], b};
        end
    endtask

    task automatic tick();
        logic [7:0] w;
        logic [0:0] e;
        logic [3:0] se;
        if (lb == 2)      chk_data = 1'($urandom);
        else if (lb == 1) chk_data = ~gen_data;
        else              chk_data = gen_data ^ flip;
        flip = 1'b0;
        s_chk_data = s_inv ? ~s_gen_data : s_gen_data;
        if (mode != m_mode) begin
            m_st = '1;
            m_mode = mode;
        end else if (gen_en) begin
            model_word(m_st, 1, mode, w);
            m_last = w[0];
        end
        exp_q.push_back(m_last);
        if (s_gen_en) begin
            model_word(s_st, 4, 2'd0, w);
            s_last = w[3:0];
        end
        s_exp_q.push_back(s_last);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("gen", 32'(gen_data), 32'(e));
        se = s_exp_q.pop_front();
        check("s_gen", 32'(s_gen_data), 32'(se));
        pulses   += int'(err_pulse);
        s_pulses += int'(s_err_pulse);
        if (!locked) lost++;
    endtask

    initial begin
        rst_n = 1'b0;
        gen_en = 1'b1; chk_valid = 1'b1; clr_cnt = 1'b0; mode = 2'd0;
        s_gen_en = 1'b1; s_chk_valid = 1'b1; s_clr = 1'b0; s_mode = 2'd0;
        chk_data = '0; s_chk_data = '0; flip = 1'b0; s_inv = 1'b0; lb = 0;
        m_st = '1; s_st = '1; m_mode = 2'd0; m_last = '0; s_last = '0;
        pulses = 0; s_pulses = 0; lost = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gen", 32'(gen_data), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_pulse", 32'(err_pulse), 0);
        check("rst_count", 32'(err_count), 0);
        check("rst_s_gen", 32'(s_gen_data), 0);
        rst_n = 1'b1;

        lock_at = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            hist[k] = gen_data;
            if (locked && lock_at == 0) lock_at = k + 1;
        end
        for (int k = 0; k < 7; k++) first7[6-k] = hist[k][0];
        check("first7", 32'(first7), 32'h01);
        mism = 0;
        for (int k = 0; k < 150; k++) if (hist[k] !== hist[k+127]) mism++;
        check("period127", mism, 0);
        check("lock_time", 32'(lock_at > 0 && lock_at <= 73), 1);
        check("s_lock", 32'(s_locked), 1);

        pulses = 0; lost = 0;
        repeat (10000) tick();
        check("clean_count", 32'(err_count), 0);
        check("clean_pulses", pulses, 0);
        check("clean_lost", lost, 0);
        check("s_clean_count", 32'(s_err_count), 0);

        pulses = 0; lost = 0; flip = 1'b1;
        repeat (40) tick();
        check("flip_count", 32'(err_count), 3);
        check("flip_pulses", pulses, 3);
        check("flip_lost", lost, 0);

        lb = 1; pulses = 0;
        repeat (3) tick();
        check("inv3_locked", 32'(locked), 1);
        tick();
        check("inv4_locked", 32'(locked), 0);
        check("inv_count", 32'(err_count), 7);
        check("inv_pulses", pulses, 4);
        lb = 2;
        repeat (300) tick();
        check("noise_count", 32'(err_count), 7);
        check("noise_locked", 32'(locked), 0);

        lb = 0; mode = 2'd3;
        tick();
        check("m3_count", 32'(err_count), 0);
        check("m3_locked", 32'(locked), 0);
        lock_at = 0;
        for (int k = 1; k <= 97; k++) begin
            tick();
            if (locked && lock_at == 0) lock_at = k;
        end
        check("m3_lock", 32'(lock_at > 0), 1);
        pulses = 0; lost = 0; flip = 1'b1;
        repeat (40) tick();
        check("m3_flip_count", 32'(err_count), 3);
        check("m3_flip_pulses", pulses, 3);
        check("m3_flip_lost", lost, 0);

        mode = 2'd1;
        tick();
        check("m1_locked", 32'(locked), 0);
        check("m1_count", 32'(err_count), 0);
        lock_at = 0;
        for (int k = 1; k <= 81; k++) begin
            tick();
            if (locked && lock_at == 0) lock_at = k;
        end
        check("m1_relock", 32'(lock_at > 0), 1);
        mode = 2'd2;
        repeat (100) tick();

        s_inv = 1'b1;
        repeat (20) tick();
        check("sat_count", 32'(s_err_count), 15);
        check("sat_locked", 32'(s_locked), 1);
        s_clr = 1'b1;
        tick();
        check("clr_wins", 32'(s_err_count), 0);
        s_clr = 1'b0;
        tick();
        check("post_clr_count", 32'(s_err_count), 4);
        check("post_clr_pulse", 32'(s_err_pulse), 1);

        #3;
        rst_n = 1'b0;
        #1;
        check("arst_s_locked", 32'(s_locked), 0);
        check("arst_s_count", 32'(s_err_count), 0);
        check("arst_s_gen", 32'(s_gen_data), 0);
        check("arst_gen", 32'(gen_data), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prbs_gen_chk.md
Name: prbs_gen_chk

Overview:
Parametrised PRBS generator and self-synchronising checker for pad-level link and bring-up testing.
- Generator emits DATA_W bits per enabled cycle.
- Polynomial is run-time selectable: PRBS7, PRBS15, PRBS23 or PRBS31.
- Checker locks onto a received stream, tracks lock state and counts bit errors with a saturating counter.
- Sits between the top-level pin wrapper and the pads; typical use is a loopback from gen_data to chk_data.

Parameters:
DATA_W, 1, bits generated and checked per clock; legal range 1..8.
CNT_W, 16, error counter width.
LOCK_THRESH, 64, consecutive error-free bits required in HUNT to declare lock.
UNLOCK_THRESH, 4, consecutive errored words in LOCKED that drop lock.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
gen_en  in  1  advance generator one word this cycle.
mode  in  2  polynomial select: 0=PRBS7 (x^7+x^6+1), 1=PRBS15 (x^15+x^14+1), 2=PRBS23 (x^23+x^18+1), 3=PRBS31 (x^31+x^28+1).
gen_data  out  DATA_W  generated word, registered; bit DATA_W-1 is first in time.
chk_valid  in  1  chk_data valid this cycle.
chk_data  in  DATA_W  received word, same bit order as gen_data.
clr_cnt  in  1  synchronous clear of err_count.
locked  out  1  checker in LOCKED state.
err_pulse  out  1  registered; high one cycle after a valid word that contained at least one error while LOCKED.
err_count  out  CNT_W  saturating count of error bits seen while LOCKED.

Behaviour:
Reset values:
- Generator state: all ones in the low N bits (N = polynomial degree). Checker state: all ones.
- gen_data=0, locked=0, err_pulse=0, err_count=0. FSM in HUNT.

Generator (per bit step, N/T = degree/inner tap):
- b = s[N-1] ^ s[T-1]; s <= {s[N-2:0], b}; output bit = b.
- With gen_en=1: perform DATA_W steps, load gen_data next edge. Latency 1 cycle.
- With gen_en=0: state and gen_data hold.

Checker (per received bit r, in time order):
- Predicted p = c[N-1] ^ c[T-1]; error = r ^ p; c <= {c[N-2:0], r}.
- Received bits are always shifted in, never the prediction (self-synchronising).
- Word error count = popcount of per-bit errors. Nothing changes when chk_valid=0.
- Consequence: one flipped line bit yields 3 error bits as it passes the two taps.

FSM (updated on chk_valid words only):
- HUNT:
  - Clean-bit counter += DATA_W on an error-free word; reset to 0 on any error.
  - Counter >= LOCK_THRESH -> LOCKED, effective the same edge; errored-word counter cleared.
  - Errors in HUNT are never counted.
- LOCKED:
  - Errored word: err_count += word error bits, saturating at 2^CNT_W-1; err_pulse=1; errored-word counter +1.
  - Clean word: errored-word counter = 0.
  - Errored-word counter reaching UNLOCK_THRESH -> HUNT; clean-bit counter = 0.
  - err_count is retained across loss of lock.
- locked and err_count registered; 1-cycle latency from chk_valid word.

Boundary conditions:
- clr_cnt concurrent with an increment: clear wins, err_count=0.
- Saturated counter holds at all ones.
- mode change (registered compare against previous mode), effective next edge:
  - Both LFSRs reload all-ones seed.
  - FSM -> HUNT, counters zeroed, err_count cleared.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).

Optional Feature:
PRBS_ERR_INJECT_EN:
- Defined: adds input port inject_err (1 bit).
- A rising edge of inject_err, sampled in clk domain, inverts bit DATA_W-1 of the next generated word only.
- Generator LFSR state is unaffected, so the stream stays on-sequence.
- Undefined: port absent, generator output unmodified.

Test Plan:
- Reset, mode=0, DATA_W=1, gen_en=1: gen_data first 7 bits 0,0,0,0,0,0,1; sequence repeats with period 127 -> pass.
- Loopback gen_data->chk_data, chk_valid=gen_en=1, LOCK_THRESH=64: locked rises within 64+N+2 cycles; err_count stays 0 for 10000 cycles.
- After lock, flip one line bit in the loopback: err_count = 3, err_pulse high for 3 single-cycle pulses, locked stays 1.
- After lock, drive chk_data=random noise: locked falls after 4 consecutive errored words; err_count frozen thereafter while in HUNT.
- CNT_W=4, continuous errors while LOCKED with UNLOCK_THRESH large: err_count saturates at 15; clr_cnt asserted together with an errored word -> err_count=0.
- Locked on PRBS31 (mode=3), switch to mode=1: locked=0 and err_count=0 next cycle; relock on PRBS15 within LOCK_THRESH+17 cycles.
